// File: rtl/soi_fault_injector.sv
// soi_fault_injector: in-line fault injector that corrupts a signal of interest after a programmable delay.
module soi_fault_injector #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_delay,
  input  logic [CNT_W-1:0] cmd_duration,
  input  logic             cancel,
  input  logic [WIDTH-1:0] soi_in,
  output logic [WIDTH-1:0] soi_out,
  output logic             inj_active,
  output logic             inj_done,
  output logic [CNT_W-1:0] inj_count
);
  typedef enum logic [1:0] {IDLE, ARMED, INJECT} state_t;
  state_t           r_state, w_next;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_mask;
  logic [CNT_W-1:0] r_dcnt, r_lcnt, r_count;
  logic             r_active, r_done;
  logic             w_accept, w_fin;
  assign w_accept = cmd_valid && cmd_ready && cmd_mode != 2'b11;
  // r_lcnt stays 0 for a permanent injection, so it never reaches the finish condition
  assign w_fin = r_state == INJECT && !cancel && r_lcnt == CNT_W'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_mode   <= '0;
      r_mask   <= '0;
      r_dcnt   <= '0;
      r_lcnt   <= '0;
      r_count  <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_active <= w_next == INJECT;
      r_done   <= w_fin;
      if (w_fin && r_count != '1) r_count <= r_count + 1'b1;
      if (w_accept) begin
        r_mode <= cmd_mode;
        r_mask <= cmd_mask;
        // delay D faults cycle D after acceptance; ARMED covers the D-1 cycles in between
        r_dcnt <= cmd_delay - 1'b1;
        r_lcnt <= cmd_duration;
      end else begin
        if (r_state == ARMED) r_dcnt <= r_dcnt - 1'b1;
        if (r_state == INJECT && r_lcnt != '0) r_lcnt <= r_lcnt - 1'b1;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = !w_accept ? IDLE : cmd_delay <= CNT_W'(1) ? INJECT : ARMED;
      ARMED:   w_next = cancel ? IDLE : r_dcnt == CNT_W'(1) ? INJECT : ARMED;
      INJECT:  w_next = (cancel || w_fin) ? IDLE : INJECT;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = r_state == IDLE && !reset;
    soi_out   = !r_active          ? soi_in :
                r_mode == 2'b00    ? soi_in ^ r_mask :
                r_mode == 2'b01    ? soi_in & ~r_mask :
                                     soi_in | r_mask;
  end
  assign inj_active = r_active;
  assign inj_done   = r_done;
  assign inj_count  = r_count;
endmodule
